// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: shared opcodes, state encoding, ALU B-operand selects and control bundle
//   for the multicycle MIPS-16 control sequencer.
package mc_ctrl_fsm_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, HALT
    } state_e;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_SEXT4 = 2'd2;
    localparam logic [1:0] SRCB_SEXT8 = 2'd3;

    typedef struct packed {
        logic [3:0] alu_opcod;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return is_rtype(op) || op inside {OP_LW, OP_SW, OP_BNE, OP_HALT};
    endfunction
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: control bus between the sequencer (master) and the datapath (slave).
//   Datapath -> sequencer: ir, mem_ready, alu_eq, alu_v.
//   Sequencer -> datapath: ALU opcode/operand selects, memory request, IR/PC/regfile enables.
interface mc_ctrl_fsm_if;
    logic [15:0] ir;
    logic        mem_ready;
    logic        alu_eq;
    logic        alu_v;
    logic [3:0]  alu_opcod;
    logic        alu_srca;
    logic [1:0]  alu_srcb;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;

    modport master (
        input  ir, mem_ready, alu_eq, alu_v,
        output alu_opcod, alu_srca, alu_srcb, mem_req, mem_we, iord,
               ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg
    );

    modport slave (
        output ir, mem_ready, alu_eq, alu_v,
        input  alu_opcod, alu_srca, alu_srcb, mem_req, mem_we, iord,
               ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> control-output table for the sequencer.
//   state_i     current state
//   op_i        ir[15:12]
//   mem_ready_i qualifies ir_we/pc_we in FETCH
//   alu_eq_i    qualifies pc_we in BRANCH
//   ovf_i       registered overflow of the current R-type; suppresses writeback
//   en_i        0 forces every control output low (held in reset)
//   ctrl_o      control bundle
module mc_ctrl_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] op_i,
    input  logic       mem_ready_i,
    input  logic       alu_eq_i,
    input  logic       ovf_i,
    input  logic       en_i,
    output ctrl_t      ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.alu_opcod = OP_ADD;
                ctrl_o.alu_srcb  = SRCB_ONE;
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.ir_we     = mem_ready_i;
                ctrl_o.pc_we     = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_opcod = OP_ADD;
                ctrl_o.alu_srcb  = SRCB_SEXT8;
            end
            EXEC_R: begin
                ctrl_o.alu_opcod = op_i;
                ctrl_o.alu_srca  = 1'b1;
                ctrl_o.alu_srcb  = SRCB_REG;
            end
            WB_R: begin
                ctrl_o.reg_we  = !ovf_i;
                ctrl_o.reg_dst = 1'b1;
            end
            ADDR: begin
                ctrl_o.alu_opcod = op_i;
                ctrl_o.alu_srca  = 1'b1;
                ctrl_o.alu_srcb  = SRCB_SEXT4;
            end
            MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            WB_MEM: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_opcod = OP_SUB;
                ctrl_o.alu_srca  = 1'b1;
                ctrl_o.alu_srcb  = SRCB_REG;
                ctrl_o.pc_we     = !alu_eq_i;
                ctrl_o.pc_src    = 1'b1;
            end
            default: ;
        endcase
        if (!en_i) ctrl_o = '0;
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control sequencer for the 16-bit MIPS datapath.
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        mc_ctrl_fsm_if.master: ir/mem_ready/alu_eq/alu_v in, ALU/memory/enable controls out
//   halted_o   sticky, set by HALT
//   illegal_o  sticky, set by an undefined opcode
//   ovf_err_o  sticky, set by ADD/SUB overflow
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mc_ctrl_fsm_if.master bus,
    output logic halted_o,
    output logic illegal_o,
    output logic ovf_err_o
);
    state_e     state_q, state_d;
    logic       ovf_q, ovf_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic       ovf_err_q, ovf_err_d;
    logic [3:0] op;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign op        = bus.ir[15:12];
    assign unused_ir = ^bus.ir[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            ovf_q     <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: state_d = is_rtype(op) ? EXEC_R :
                              op inside {OP_LW, OP_SW} ? ADDR :
                              op == OP_BNE ? BRANCH :
                              op == OP_HALT ? HALT : FETCH;
            EXEC_R: state_d = WB_R;
            ADDR:   state_d = op == OP_LW ? MEM_RD : MEM_WR;
            MEM_RD: state_d = bus.mem_ready ? WB_MEM : MEM_RD;
            MEM_WR: state_d = bus.mem_ready ? FETCH : MEM_WR;
            HALT:   state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Overflow only matters for ADD/SUB; captured in EXEC_R, consumed in WB_R.
    assign ovf_d     = state_q == EXEC_R ? bus.alu_v && op inside {OP_ADD, OP_SUB} : ovf_q;
    assign halted_d  = halted_q  || (state_q == DECODE && op == OP_HALT);
    assign illegal_d = illegal_q || (state_q == DECODE && !is_legal(op));
    assign ovf_err_d = ovf_err_q || (state_q == WB_R && ovf_q);

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op),
        .mem_ready_i (bus.mem_ready),
        .alu_eq_i    (bus.alu_eq),
        .ovf_i       (ovf_q),
        .en_i        (!rst),
        .ctrl_o      (ctrl)
    );

    assign bus.alu_opcod  = ctrl.alu_opcod;
    assign bus.alu_srca   = ctrl.alu_srca;
    assign bus.alu_srcb   = ctrl.alu_srcb;
    assign bus.mem_req    = ctrl.mem_req;
    assign bus.mem_we     = ctrl.mem_we;
    assign bus.iord       = ctrl.iord;
    assign bus.ir_we      = ctrl.ir_we;
    assign bus.pc_we      = ctrl.pc_we;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.reg_we     = ctrl.reg_we;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign halted_o       = halted_q;
    assign illegal_o      = illegal_q;
    assign ovf_err_o      = ovf_err_q;
endmodule
